mem_port_arbiter: RTL and testbench

// Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.

---
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake between the memory port arbiter (master) and the single-ported unified memory (slave).
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; data wins by default,
// a starvation counter forces a fetch grant after STARVE_MAX contested data grants.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  PCF,
   input  logic               FetchReqF,
   input  logic               FlushF,
   input  logic [ADDR_W-1:0]  ALUOutM,
   input  logic [DATA_W-1:0]  WriteDataM,
   input  logic               MemReadM,
   input  logic               MemWriteM,
   output logic [DATA_W-1:0]  InstrF,
   output logic [DATA_W-1:0]  ReadDataM,
   output logic               StallF,
   output logic               StallM,
   mem_port_arbiter_if.master mem
);
   localparam int unsigned      CNT_W      = 4;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [2:0] {IDLE, DATA, FETCH, DONE_D, DONE_F} arbStateT;

   arbStateT          state;
   arbStateT          stateNext;
   logic              memReq;
   logic              memReqNext;
   logic              memWe;
   logic              memWeNext;
   logic [ADDR_W-1:0] memAddr;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] wdataNext;
   logic [DATA_W-1:0] instrNext;
   logic [DATA_W-1:0] readDataNext;
   logic [CNT_W-1:0]  starveCnt;
   logic [CNT_W-1:0]  starveNext;
   logic              discard;
   logic              discardNext;
   logic              fetchDone;
   logic              fetchDoneNext;
   logic              dataDone;
   logic              dataDoneNext;
   logic              dataReq;
   logic              fetchPriority;
   logic              flushed;

   // Next-state and next-register values
   always_comb begin
      stateNext     = state;
      memWeNext     = memWe;
      addrNext      = memAddr;
      wdataNext     = memWdata;
      instrNext     = InstrF;
      readDataNext  = ReadDataM;
      starveNext    = starveCnt;
      discardNext   = discard;
      flushed       = 1'b0;
      dataReq       = MemReadM | MemWriteM;
      fetchPriority = FetchReqF && (starveCnt == STARVE_LIM);

      case (state)
         IDLE: begin
            discardNext = 1'b0;
            if (dataReq && !fetchPriority) begin
               stateNext = DATA;
               addrNext  = ALUOutM;
               wdataNext = WriteDataM;
               memWeNext = MemWriteM;
               if (FetchReqF && (starveCnt < STARVE_LIM)) begin
                  starveNext = starveCnt + CNT_W'(1);
               end
            end else if (FetchReqF) begin
               stateNext  = FETCH;
               addrNext   = PCF;
               memWeNext  = 1'b0;
               starveNext = '0;
            end
         end
         DATA: begin
            if (mem.mem_ack) begin
               if (!memWe) begin
                  readDataNext = mem.mem_rdata;
               end
               stateNext = DONE_D;
            end
         end
         FETCH: begin
            // A flush in the ack cycle still squashes the returning instruction
            flushed     = discard | FlushF;
            discardNext = flushed;
            if (mem.mem_ack) begin
               if (flushed) begin
                  stateNext   = IDLE;
                  discardNext = 1'b0;
               end else begin
                  instrNext = mem.mem_rdata;
                  stateNext = DONE_F;
               end
            end
         end
         DONE_D:  stateNext = IDLE;
         DONE_F:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      memReqNext    = (stateNext == DATA) || (stateNext == FETCH);
      dataDoneNext  = (stateNext == DONE_D);
      fetchDoneNext = (stateNext == DONE_F);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         memReq    <= 1'b0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memWdata  <= '0;
         InstrF    <= '0;
         ReadDataM <= '0;
         starveCnt <= '0;
         discard   <= 1'b0;
         fetchDone <= 1'b0;
         dataDone  <= 1'b0;
      end else begin
         state     <= stateNext;
         memReq    <= memReqNext;
         memWe     <= memWeNext;
         memAddr   <= addrNext;
         memWdata  <= wdataNext;
         InstrF    <= instrNext;
         ReadDataM <= readDataNext;
         starveCnt <= starveNext;
         discard   <= discardNext;
         fetchDone <= fetchDoneNext;
         dataDone  <= dataDoneNext;
      end
   end

   assign mem.mem_req   = memReq;
   assign mem.mem_we    = memWe;
   assign mem.mem_addr  = memAddr;
   assign mem.mem_wdata = memWdata;

   assign StallF = FetchReqF & ~fetchDone;
   assign StallM = (MemReadM | MemWriteM) & ~dataDone;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] PCF;
   logic              FetchReqF;
   logic              FlushF;
   logic [ADDR_W-1:0] ALUOutM;
   logic [DATA_W-1:0] WriteDataM;
   logic              MemReadM;
   logic              MemWriteM;
   logic [DATA_W-1:0] InstrF;
   logic [DATA_W-1:0] ReadDataM;
   logic              StallF;
   logic              StallM;

   int cmpCnt = 0;
   int errCnt = 0;

   // memory responder state
   logic [31:0] memArr [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];
   bit randLat  = 0;
   int fixedLat = 1;
   int waitCnt  = 0;
   int curLat   = 1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memBus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk        (clk),
      .reset      (reset),
      .PCF        (PCF),
      .FetchReqF  (FetchReqF),
      .FlushF     (FlushF),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .InstrF     (InstrF),
      .ReadDataM  (ReadDataM),
      .StallF     (StallF),
      .StallM     (StallM),
      .mem        (memBus.master)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] defVal(logic [31:0] a);
      return a * 32'd7 + 32'h0BAD_0000;
   endfunction

   function automatic logic [31:0] memRd(logic [31:0] a);
      if (memArr.exists(a)) return memArr[a];
      return defVal(a);
   endfunction

   function automatic logic [31:0] refRd(logic [31:0] a);
      if (refMem.exists(a)) return refMem[a];
      return defVal(a);
   endfunction

   // Memory: acks curLat cycles after mem_req rises (1 = same cycle)
   initial begin
      memBus.mem_ack   = 1'b0;
      memBus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || !memBus.mem_req) begin
            memBus.mem_ack = 1'b0;
            waitCnt = 0;
         end else begin
            waitCnt++;
            if (waitCnt == 1) curLat = randLat ? int'($urandom_range(1, 4)) : fixedLat;
            if (waitCnt == curLat) begin
               memBus.mem_ack   = 1'b1;
               memBus.mem_rdata = memRd(memBus.mem_addr);
               if (memBus.mem_we) memArr[memBus.mem_addr] = memBus.mem_wdata;
            end else begin
               memBus.mem_ack = 1'b0;
            end
         end
      end
   end

   // an abandoned access is forgotten by the memory
   initial forever begin
      @(posedge reset);
      waitCnt = 0;
      memBus.mem_ack = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic dropReqs();
      FetchReqF = 0; FlushF = 0; MemReadM = 0; MemWriteM = 0;
   endtask

   task automatic doReset();
      dropReqs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      dropReqs();
      PCF = '0; ALUOutM = '0; WriteDataM = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      cmpCnt++;
      if ({memBus.mem_req, memBus.mem_we, StallF, StallM} !== 4'b0000) begin
         errCnt++;
         $display("FAIL reset_ctrl: got req/we/stallF/stallM=%b want 0000",
                  {memBus.mem_req, memBus.mem_we, StallF, StallM});
      end
      cmpCnt++;
      if ({memBus.mem_addr, memBus.mem_wdata} !== 64'h0) begin
         errCnt++;
         $display("FAIL reset_bus: got addr=%h wdata=%h want 0", memBus.mem_addr, memBus.mem_wdata);
      end
      cmpCnt++;
      if ({InstrF, ReadDataM} !== 64'h0) begin
         errCnt++;
         $display("FAIL reset_out: got InstrF=%h ReadDataM=%h want 0", InstrF, ReadDataM);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load();
      int reqCycles = 0;
      memArr[32'h40] = 32'h0000_1234;
      randLat = 0; fixedLat = 2;
      ALUOutM = 32'h40; MemReadM = 1;
      #1;
      cmpCnt++;
      if (StallM !== 1'b1) begin errCnt++; $display("FAIL load_stall_c0: got %b want 1", StallM); end
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (memBus.mem_req) reqCycles++;
         cmpCnt++;
         if (StallM !== (c < 3)) begin
            errCnt++; $display("FAIL load_stall_c%0d: got %b want %b", c, StallM, (c < 3));
         end
         if (c == 1) begin
            cmpCnt++;
            if ({memBus.mem_we, memBus.mem_addr} !== {1'b0, 32'h40}) begin
               errCnt++; $display("FAIL load_bus: got we=%b addr=%h want 0/40", memBus.mem_we, memBus.mem_addr);
            end
         end
      end
      cmpCnt++;
      if (ReadDataM !== 32'h1234) begin errCnt++; $display("FAIL load_data: got %h want 00001234", ReadDataM); end
      MemReadM = 0;
      cmpCnt++;
      if (reqCycles != 2) begin errCnt++; $display("FAIL load_req_cycles: got %0d want 2", reqCycles); end
      tick();
      cmpCnt++;
      if ({memBus.mem_req, StallM} !== 2'b00) begin
         errCnt++; $display("FAIL load_idle: got req/stall=%b want 00", {memBus.mem_req, StallM});
      end
   endtask

   task automatic test_fetch();
      memArr[32'h100] = 32'h8C41_0004;
      randLat = 0; fixedLat = 1;
      PCF = 32'h100; FetchReqF = 1;
      #1;
      cmpCnt++;
      if (StallF !== 1'b1) begin errCnt++; $display("FAIL fetch_stall_c0: got %b want 1", StallF); end
      tick();
      cmpCnt++;
      if ({StallF, memBus.mem_req, memBus.mem_we, memBus.mem_addr} !== {3'b110, 32'h100}) begin
         errCnt++;
         $display("FAIL fetch_c1: got stall=%b req=%b we=%b addr=%h want 1/1/0/100",
                  StallF, memBus.mem_req, memBus.mem_we, memBus.mem_addr);
      end
      tick();
      cmpCnt++;
      if ({StallF, memBus.mem_req} !== 2'b00) begin
         errCnt++; $display("FAIL fetch_c2: got stall/req=%b want 00", {StallF, memBus.mem_req});
      end
      cmpCnt++;
      if (InstrF !== 32'h8C41_0004) begin errCnt++; $display("FAIL fetch_instr: got %h want 8c410004", InstrF); end
      FetchReqF = 0;
      tick();
   endtask

   task automatic test_store_read();
      randLat = 0; fixedLat = 1;
      ALUOutM = 32'h44; WriteDataM = 32'hDEAD_BEEF; MemReadM = 1; MemWriteM = 1;
      tick();
      cmpCnt++;
      if ({memBus.mem_we, memBus.mem_addr, memBus.mem_wdata} !== {1'b1, 32'h44, 32'hDEAD_BEEF}) begin
         errCnt++;
         $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1/44/deadbeef",
                  memBus.mem_we, memBus.mem_addr, memBus.mem_wdata);
      end
      tick();
      cmpCnt++;
      if (StallM !== 1'b0) begin errCnt++; $display("FAIL store_stall: got %b want 0", StallM); end
      cmpCnt++;
      if (ReadDataM !== 32'h1234) begin errCnt++; $display("FAIL store_rdata: got %h want 00001234", ReadDataM); end
      cmpCnt++;
      if (memRd(32'h44) !== 32'hDEAD_BEEF) begin
         errCnt++; $display("FAIL store_mem: got %h want deadbeef", memRd(32'h44));
      end
      dropReqs();
      tick();
   endtask

   task automatic test_flush();
      bit done = 0;
      bit gotReq = 0;
      memArr[32'h200] = 32'h1111_1111;
      memArr[32'h280] = 32'h2222_2222;
      randLat = 0; fixedLat = 3;
      PCF = 32'h200; FetchReqF = 1;
      tick();
      cmpCnt++;
      if ({memBus.mem_req, memBus.mem_addr} !== {1'b1, 32'h200}) begin
         errCnt++; $display("FAIL flush_grant: got req=%b addr=%h want 1/200", memBus.mem_req, memBus.mem_addr);
      end
      FlushF = 1; PCF = 32'h280;
      for (int c = 2; c <= 4; c++) begin
         tick();
         FlushF = 0;
         cmpCnt++;
         if (StallF !== 1'b1) begin errCnt++; $display("FAIL flush_stall_c%0d: got %b want 1", c, StallF); end
      end
      cmpCnt++;
      if ({memBus.mem_req, InstrF} !== {1'b0, 32'h8C41_0004}) begin
         errCnt++; $display("FAIL flush_idle: got req=%b InstrF=%h want 0/8c410004", memBus.mem_req, InstrF);
      end
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         if (memBus.mem_req && !gotReq) begin
            gotReq = 1;
            cmpCnt++;
            if (memBus.mem_addr !== 32'h280) begin
               errCnt++; $display("FAIL flush_refetch_addr: got %h want 280", memBus.mem_addr);
            end
         end
         if (!StallF) begin
            done = 1;
            cmpCnt++;
            if (InstrF !== 32'h2222_2222) begin errCnt++; $display("FAIL flush_refetch: got %h want 22222222", InstrF); end
         end
      end
      if (!done) begin cmpCnt++; errCnt++; $display("FAIL flush_timeout: got no fetch_done want one within 20 cycles"); end
      dropReqs();
      tick();
   endtask

   task automatic test_reset_mid();
      randLat = 0; fixedLat = 10;
      ALUOutM = 32'h40; MemReadM = 1;
      tick();
      cmpCnt++;
      if (memBus.mem_req !== 1'b1) begin errCnt++; $display("FAIL rstmid_req_before: got %b want 1", memBus.mem_req); end
      tick();
      #3 reset = 1'b1;
      #1;
      cmpCnt++;
      if ({memBus.mem_req, ReadDataM} !== {1'b0, 32'h0}) begin
         errCnt++; $display("FAIL rstmid_async: got req=%b rdata=%h want 0/0", memBus.mem_req, ReadDataM);
      end
      fixedLat = 1;
      #1 reset = 1'b0;
      tick();
      cmpCnt++;
      if ({memBus.mem_req, memBus.mem_addr} !== {1'b1, 32'h40}) begin
         errCnt++; $display("FAIL rstmid_restart: got req=%b addr=%h want 1/40", memBus.mem_req, memBus.mem_addr);
      end
      tick();
      cmpCnt++;
      if ({StallM, ReadDataM} !== {1'b0, 32'h1234}) begin
         errCnt++; $display("FAIL rstmid_done: got stall=%b rdata=%h want 0/00001234", StallM, ReadDataM);
      end
      dropReqs();
      tick();
   endtask

   task automatic test_starvation();
      int g = 0;
      bit prevReq = 0;
      bit isF;
      doReset();
      randLat = 1;
      ALUOutM = 32'h300; PCF = 32'h380; MemReadM = 1; FetchReqF = 1;
      for (int k = 0; k < 400 && g < 15; k++) begin
         tick();
         if (memBus.mem_req && !prevReq) begin
            isF = (memBus.mem_addr == 32'h380);
            cmpCnt++;
            if (isF !== ((g % 5) == 4)) begin
               errCnt++; $display("FAIL starve_grant%0d: got fetch=%b want %b", g, isF, ((g % 5) == 4));
            end
            g++;
         end
         prevReq = memBus.mem_req;
      end
      if (g < 15) begin cmpCnt++; errCnt++; $display("FAIL starve_timeout: got %0d grants want 15", g); end
      dropReqs();
      randLat = 0;
      repeat (6) tick();
   endtask

   task automatic test_random();
      int modelCnt = 0;
      bit prevReq = 0;
      int fAge = 0;
      int dAge = 0;
      bit expData;
      logic expWe;
      logic [31:0] expAddr;
      logic [31:0] lastLoad = '0;
      logic [31:0] expRd;
      int r;
      doReset();
      memArr.delete();
      refMem.delete();
      randLat = 1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         // grant decided from the inputs held during the preceding IDLE cycle
         if (memBus.mem_req && !prevReq) begin
            expData = (MemReadM || MemWriteM) && !(FetchReqF && modelCnt == int'(STARVE_MAX));
            expWe   = expData ? MemWriteM : 1'b0;
            expAddr = expData ? ALUOutM : PCF;
            cmpCnt++;
            if ({memBus.mem_we, memBus.mem_addr} !== {expWe, expAddr}) begin
               errCnt++;
               $display("FAIL rand_grant@%0d: got we=%b addr=%h want we=%b addr=%h",
                        cyc, memBus.mem_we, memBus.mem_addr, expWe, expAddr);
            end
            if (!expData) modelCnt = 0;
            else if (FetchReqF && modelCnt < int'(STARVE_MAX)) modelCnt++;
         end
         prevReq = memBus.mem_req;

         if (FetchReqF && !StallF) begin
            cmpCnt++;
            if (InstrF !== refRd(PCF)) begin
               errCnt++; $display("FAIL rand_instr@%0d: got %h want %h", cyc, InstrF, refRd(PCF));
            end
            FetchReqF = 0; fAge = 0;
         end else if (FetchReqF) begin
            fAge++;
         end else if ($urandom_range(0, 2) == 0) begin
            FetchReqF = 1;
            PCF = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
         end

         if ((MemReadM || MemWriteM) && !StallM) begin
            if (MemWriteM) begin
               expRd = lastLoad;
               refMem[ALUOutM] = WriteDataM;
            end else begin
               expRd = refRd(ALUOutM);
               lastLoad = expRd;
            end
            cmpCnt++;
            if (ReadDataM !== expRd) begin
               errCnt++; $display("FAIL rand_rdata@%0d: got %h want %h", cyc, ReadDataM, expRd);
            end
            MemReadM = 0; MemWriteM = 0; dAge = 0;
         end else if (MemReadM || MemWriteM) begin
            dAge++;
         end else begin
            r = int'($urandom_range(0, 5));
            if (r < 3) begin
               MemReadM   = (r != 1);
               MemWriteM  = (r != 0);
               ALUOutM    = 32'($urandom_range(0, 15)) * 32'd4;
               WriteDataM = $urandom;
            end
         end

         if (fAge > 100 || dAge > 100) begin
            cmpCnt++; errCnt++;
            $display("FAIL rand_timeout@%0d: got fetch age %0d data age %0d want <=100", cyc, fAge, dAge);
            break;
         end
      end
      dropReqs();
      randLat = 0;
      repeat (8) tick();
   endtask

   initial begin
      dropReqs();
      test_reset();
      test_load();
      test_fetch();
      test_store_read();
      test_flush();
      test_reset_mid();
      test_starvation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end
endmodule
